// File: rtl/alarm_clock_core.sv
// alarm_clock_core: 24 h timekeeping with time/alarm setting, ring/snooze alarms, hourly chime and 12/24 h display.
module alarm_clock_core #(
  parameter int TICK_DIV   = 100000000,
  parameter int NUM_ALARMS = 2,
  parameter int RING_SECS  = 30,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [2:0]            sel,
  input  logic                  h_inc,
  input  logic                  m_inc,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  mode12,
  input  logic                  chime_en,
  input  logic                  snooze,
  input  logic                  stop,
  output logic [4:0]            hour,
  output logic [5:0]            minute,
  output logic [5:0]            second,
  output logic [4:0]            disp_hour,
  output logic [5:0]            disp_min,
  output logic [5:0]            disp_sec,
  output logic                  pm,
  output logic                  sec_tick,
  output logic                  chime,
  output logic                  ringing,
  output logic [2:0]            ring_id
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int RW = $clog2(RING_SECS + 1);
  localparam int SNOOZE_TICKS = SNOOZE_MIN * 60;
  localparam int SW = $clog2(SNOOZE_TICKS + 1);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
  state_t state, state_n;
  logic [PW-1:0] pcnt;
  logic [RW-1:0] rcnt, rcnt_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [2:0] rid_n, sel_v, hit_id;
  logic [4:0] al_h [NUM_ALARMS];
  logic [5:0] al_m [NUM_ALARMS];
  logic [4:0] nh, sh;
  logic [5:0] nm, ns, sm, ss;
  logic time_edit, adv, s_wrap, m_wrap, hit, match, en_cur;
  assign sec_tick  = pcnt == PW'(TICK_DIV - 1);
  assign sel_v     = sel > 3'(NUM_ALARMS) ? 3'd0 : sel;
  assign time_edit = sel_v == 3'd0 && (h_inc || m_inc);
  assign adv       = sec_tick && run && !time_edit;
  assign s_wrap    = second == 6'd59;
  assign m_wrap    = minute == 6'd59;
  assign ns        = s_wrap ? 6'd0 : second + 6'd1;
  assign nm        = s_wrap ? (m_wrap ? 6'd0 : minute + 6'd1) : minute;
  assign nh        = s_wrap && m_wrap ? (hour == 5'd23 ? 5'd0 : hour + 5'd1) : hour;
  assign match     = adv && s_wrap && hit;
  assign en_cur    = |(alarm_en & (NUM_ALARMS'(1) << ring_id));
  assign ringing   = state == RING;
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
      {hour, minute, second} <= '0;
      chime <= 1'b0;
    end else begin
      pcnt <= sec_tick ? '0 : pcnt + 1'b1;
      chime <= adv && chime_en && nm == 6'd0 && ns == 6'd0;
      if (time_edit) begin
        if (h_inc) hour <= hour == 5'd23 ? 5'd0 : hour + 5'd1;
        if (m_inc) begin
          minute <= m_wrap ? 6'd0 : minute + 6'd1;
          second <= 6'd0;
        end
      end else if (adv) begin
        {hour, minute, second} <= {nh, nm, ns};
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (rst) begin
        al_h[i] <= 5'd0;
        al_m[i] <= 6'd0;
      end else if (sel_v == 3'(i + 1)) begin
        if (h_inc) al_h[i] <= al_h[i] == 5'd23 ? 5'd0 : al_h[i] + 5'd1;
        if (m_inc) al_m[i] <= al_m[i] == 6'd59 ? 6'd0 : al_m[i] + 6'd1;
      end
    end
  end
  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0;
    hit_id = 3'd0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (alarm_en[i] && al_h[i] == nh && al_m[i] == nm) begin
        hit = 1'b1;
        hit_id = 3'(i);
      end
  end
  always_comb begin
    sh = hour;
    sm = minute;
    ss = second;
    for (int i = 0; i < NUM_ALARMS; i++)
      if (sel_v == 3'(i + 1)) begin
        sh = al_h[i];
        sm = al_m[i];
        ss = 6'd0;
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {disp_hour, disp_min, disp_sec, pm} <= '0;
    end else begin
      disp_hour <= !mode12 ? sh : sh == 5'd0 ? 5'd12 : sh > 5'd12 ? sh - 5'd12 : sh;
      disp_min  <= sm;
      disp_sec  <= ss;
      pm        <= sh >= 5'd12;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ring_id <= 3'd0;
      rcnt <= '0;
      scnt <= '0;
    end else begin
      state <= state_n;
      ring_id <= rid_n;
      rcnt <= rcnt_n;
      scnt <= scnt_n;
    end
  end
  always_comb begin
    state_n = state;
    rid_n = ring_id;
    rcnt_n = rcnt;
    scnt_n = scnt;
    case (state)
      IDLE:
        if (match) begin
          state_n = RING;
          rid_n = hit_id;
          rcnt_n = '0;
        end
      RING:
        if (stop || !en_cur) state_n = IDLE;
        else if (snooze) begin
          state_n = SNOOZE;
          scnt_n = SW'(SNOOZE_TICKS);
        end else if (sec_tick) begin
          state_n = rcnt == RW'(RING_SECS - 1) ? IDLE : RING;
          rcnt_n = rcnt + 1'b1;
        end
      SNOOZE:
        if (stop || !en_cur) state_n = IDLE;
        else if (sec_tick) begin
          scnt_n = scnt - 1'b1;
          if (scnt == SW'(1)) begin
            state_n = RING;
            rcnt_n = '0;
          end
        end
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE) rid_n = 3'd0;
  end
endmodule

// File: tb/tb_alarm_clock_core.sv
// tb_alarm_clock_core: directed and random stimulus checked every cycle against a seconds-of-day reference model.
module tb_alarm_clock_core;
  localparam int TD = 4, NA = 2, RS = 3, SM = 1;
  logic clk = 0, rst = 1, run = 0, h_inc = 0, m_inc = 0, mode12 = 0, chime_en = 0, snooze = 0, stop = 0;
  logic [2:0] sel = 0;
  logic [NA-1:0] alarm_en = 0;
  logic [4:0] hour, disp_hour;
  logic [5:0] minute, second, disp_min, disp_sec;
  logic pm, sec_tick, chime, ringing;
  logic [2:0] ring_id;
  int n_cmp = 0, n_err = 0;
  string phase = "reset";
  int pc, t, st, rid, rleft, sleft, e_dh, e_dm, e_ds, e_pm, e_chime;
  int ah [NA];
  int am [NA];

  alarm_clock_core #(.TICK_DIV(TD), .NUM_ALARMS(NA), .RING_SECS(RS), .SNOOZE_MIN(SM)) dut (
    .clk(clk), .rst(rst), .run(run), .sel(sel), .h_inc(h_inc), .m_inc(m_inc), .alarm_en(alarm_en),
    .mode12(mode12), .chime_en(chime_en), .snooze(snooze), .stop(stop), .hour(hour), .minute(minute),
    .second(second), .disp_hour(disp_hour), .disp_min(disp_min), .disp_sec(disp_sec), .pm(pm),
    .sec_tick(sec_tick), .chime(chime), .ringing(ringing), .ring_id(ring_id));

  always #5 clk = ~clk;

  // Reference: time as seconds of day, alarms as hour/minute, ring/snooze as remaining-tick counts.
  task automatic model_step();
    int se, sh, sm, ss, h, m, s, hit;
    bit tick, edit, adv, en_off;
    if (rst) begin
      pc = 0; t = 0; st = 0; rid = 0; rleft = 0; sleft = 0;
      e_dh = 0; e_dm = 0; e_ds = 0; e_pm = 0; e_chime = 0;
      for (int i = 0; i < NA; i++) begin ah[i] = 0; am[i] = 0; end
      return;
    end
    tick = pc == TD - 1;
    pc = tick ? 0 : pc + 1;
    se = sel > NA ? 0 : int'(sel);
    sh = se == 0 ? t / 3600 : ah[se-1];
    sm = se == 0 ? (t / 60) % 60 : am[se-1];
    ss = se == 0 ? t % 60 : 0;
    e_dh = mode12 ? (sh % 12 == 0 ? 12 : sh % 12) : sh;
    e_dm = sm; e_ds = ss; e_pm = sh >= 12 ? 1 : 0;
    edit = se == 0 && (h_inc || m_inc);
    adv = tick && run && !edit;
    e_chime = 0;
    hit = -1;
    if (edit) begin
      h = t / 3600; m = (t / 60) % 60; s = t % 60;
      if (h_inc) h = (h + 1) % 24;
      if (m_inc) begin m = (m + 1) % 60; s = 0; end
      t = h * 3600 + m * 60 + s;
    end else if (adv) begin
      t = (t + 1) % 86400;
      if (t % 3600 == 0 && chime_en) e_chime = 1;
      if (t % 60 == 0)
        for (int i = 0; i < NA; i++)
          if (hit < 0 && alarm_en[i] && ah[i] * 60 + am[i] == t / 60) hit = i;
    end
    if (se != 0) begin
      if (h_inc) ah[se-1] = (ah[se-1] + 1) % 24;
      if (m_inc) am[se-1] = (am[se-1] + 1) % 60;
    end
    en_off = st != 0 && !alarm_en[rid];
    case (st)
      0: if (hit >= 0) begin st = 1; rid = hit; rleft = RS; end
      1: if (stop || en_off) st = 0;
         else if (snooze) begin st = 2; sleft = SM * 60; end
         else if (tick) begin rleft--; if (rleft == 0) st = 0; end
      default: if (stop || en_off) st = 0;
         else if (tick) begin sleft--; if (sleft == 0) begin st = 1; rleft = RS; end end
    endcase
    if (st == 0) rid = 0;
  endtask

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s/%s: got %0d want %0d", phase, name, act, exp);
    end
  endtask

  task automatic check_all();
    chk("hour", int'(hour), t / 3600);
    chk("minute", int'(minute), (t / 60) % 60);
    chk("second", int'(second), t % 60);
    chk("disp_hour", int'(disp_hour), e_dh);
    chk("disp_min", int'(disp_min), e_dm);
    chk("disp_sec", int'(disp_sec), e_ds);
    chk("pm", int'(pm), e_pm);
    chk("sec_tick", int'(sec_tick), pc == TD - 1 ? 1 : 0);
    chk("chime", int'(chime), e_chime);
    chk("ringing", int'(ringing), st == 1 ? 1 : 0);
    chk("ring_id", int'(ring_id), rid);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic ticks(int n);
    repeat (n * TD) cyc();
  endtask

  task automatic pulse_h(int n);
    repeat (n) begin h_inc = 1; cyc(); h_inc = 0; end
  endtask

  task automatic pulse_m(int n);
    repeat (n) begin m_inc = 1; cyc(); m_inc = 0; end
  endtask

  task automatic set_time(int h, int m);
    logic r;
    int dm;
    r = run; run = 0; sel = 0;
    pulse_h((h - t / 3600 + 24) % 24);
    dm = (m - (t / 60) % 60 + 60) % 60;
    pulse_m(dm == 0 ? 60 : dm);
    run = r;
  endtask

  initial begin
    int prev_m;
    bit found;
    model_step();
    cyc(); cyc();
    chk("reset_second", int'(second), 0);
    rst = 0;
    phase = "tick"; run = 1;
    ticks(2);
    chk("first_ticks", int'(second), 2);

    phase = "midnight";
    set_time(23, 59);
    run = 1; ticks(58);
    chk("pre_midnight_sec", int'(second), 58);
    chime_en = 1; ticks(2);
    chk("midnight", {27'd0, hour, minute}, 0);
    phase = "no_chime";
    chime_en = 0;
    set_time(0, 59);
    run = 1; ticks(60);

    phase = "alarm_set";
    sel = 1; pulse_h(7); pulse_m(30); cyc();
    chk("alarm_disp_h", int'(disp_hour), 7);
    chk("alarm_disp_m", int'(disp_min), 30);
    chk("alarm_disp_s", int'(disp_sec), 0);
    phase = "ring";
    set_time(7, 29);
    alarm_en = 2'b01; run = 1;
    ticks(59);
    chk("not_yet", int'(ringing), 0);
    ticks(1);
    chk("ring_on", int'(ringing), 1);
    ticks(3);
    chk("ring_timeout", int'(ringing), 0);

    phase = "snooze";
    set_time(7, 29);
    run = 1; ticks(60);
    chk("ring_again", int'(ringing), 1);
    snooze = 1; cyc(); snooze = 0;
    ticks(59);
    chk("snoozing", int'(ringing), 0);
    ticks(1);
    chk("snooze_ring", int'(ringing), 1);
    stop = 1; cyc(); stop = 0;
    chk("stopped", int'(ringing), 0);
    ticks(70);

    phase = "two_alarms";
    sel = 1; pulse_h(23); pulse_m(30);
    sel = 2; pulse_h(6);
    alarm_en = 2'b11;
    set_time(5, 59);
    run = 1; ticks(60);
    chk("two_ring", int'(ringing), 1);
    chk("two_id", int'(ring_id), 0);
    alarm_en = 2'b10; cyc();
    chk("en_drop", int'(ringing), 0);

    phase = "mode12";
    mode12 = 1;
    set_time(0, 0); cyc(); cyc();
    chk("h0_disp", int'(disp_hour), 12);
    set_time(13, 0); cyc(); cyc();
    chk("h13_disp", int'(disp_hour), 1);
    chk("h13_pm", int'(pm), 1);
    set_time(12, 0); cyc(); cyc();
    chk("h12_disp", int'(disp_hour), 12);
    phase = "edit_on_tick";
    run = 1; found = 0;
    for (int i = 0; i < 2 * TD && !found; i++) if (sec_tick) found = 1; else cyc();
    chk("tick_found", int'(found), 1);
    prev_m = (t / 60) % 60;
    m_inc = 1; cyc(); m_inc = 0;
    chk("edit_tick_min", int'(minute), (prev_m + 1) % 60);
    chk("edit_tick_sec", int'(second), 0);

    phase = "random";
    repeat (3000) begin
      sel = 3'($urandom_range(0, 7));
      h_inc = $urandom_range(0, 15) == 0;
      m_inc = $urandom_range(0, 7) == 0;
      snooze = $urandom_range(0, 39) == 0;
      stop = $urandom_range(0, 59) == 0;
      run = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 49) == 0) alarm_en = NA'($urandom);
      if ($urandom_range(0, 19) == 0) mode12 = ~mode12;
      if ($urandom_range(0, 19) == 0) chime_en = ~chime_en;
      cyc();
    end
    {h_inc, m_inc, snooze, stop} = 0;
    phase = "final_reset";
    rst = 1; cyc(); rst = 0; cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
